// File: rtl/fifo_col_writer.sv
// Column FIFO write-side packer: registers accepted pixel words into the FIFO, counts words/columns, and flags each completed block.
// Optional macro FIFO_WR_BACKPRESSURE_EN: pix_ready follows !fifo_full one cycle late and gates acceptance.
module fifo_col_writer #(
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_COL  = 4,
  parameter int COLS_PER_BLOCK = 138,
  parameter int FLAG_LEN       = 1
) (
  input  logic              fifo_wr_clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [WORD_W-1:0] pix_data,
  input  logic              fifo_full,
  output logic              pix_ready,
  output logic              fifo_wr_en,
  output logic [WORD_W-1:0] fifo_din,
  output logic              flag_138cols,
  output logic [7:0]        col_count,
  output logic              overflow
);

  localparam int WC_W = (WORDS_PER_COL > 1) ? $clog2(WORDS_PER_COL) : 1;
  localparam int FT_W = (FLAG_LEN > 1) ? $clog2(FLAG_LEN) : 1;
  localparam logic [WC_W-1:0] WORD_LAST = WC_W'(WORDS_PER_COL - 1);
  localparam logic [7:0]      COL_LAST  = 8'(COLS_PER_BLOCK - 1);
  localparam logic [FT_W-1:0] FT_LOAD   = FT_W'(FLAG_LEN - 1);

  typedef enum logic {S_IDLE, S_FLAG} flag_state_t;

  flag_state_t       state_reg, state_next;
  logic [FT_W-1:0]   timer_reg, timer_next;
  logic [WC_W-1:0]   word_cnt_reg, word_cnt_next, word_base;
  logic [7:0]        col_cnt_reg, col_cnt_next, col_base;
  logic              block_done_reg, block_done_next;
  logic              wr_en_reg, wr_en_next;
  logic [WORD_W-1:0] din_reg, din_next;
  logic              overflow_reg, overflow_next;
  logic              accept, drop;

`ifdef FIFO_WR_BACKPRESSURE_EN
  logic pix_ready_reg;

  always_ff @(posedge fifo_wr_clk) begin
    if (rst) pix_ready_reg <= 1'b0;
    else     pix_ready_reg <= !fifo_full;
  end

  assign pix_ready = pix_ready_reg;
  assign accept    = pix_valid && pix_ready_reg && !fifo_full;
  // Only reachable if upstream ignores pix_ready while the FIFO is full.
  assign drop      = pix_valid && !pix_ready_reg && fifo_full;
`else
  assign pix_ready = 1'b1;
  assign accept    = pix_valid && !fifo_full;
  assign drop      = pix_valid && fifo_full;
`endif

  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    din_next        = din_reg;
    overflow_next   = overflow_reg;
    wr_en_next      = 1'b0;
    block_done_next = 1'b0;

    // frame_start clears first so a same-cycle word lands as word 0 of column 0.
    word_base     = frame_start ? '0 : word_cnt_reg;
    col_base      = frame_start ? '0 : col_cnt_reg;
    word_cnt_next = word_base;
    col_cnt_next  = col_base;

    if (accept) begin
      wr_en_next = 1'b1;
      din_next   = pix_data;
      if (word_base == WORD_LAST) begin
        word_cnt_next = '0;
        if (col_base == COL_LAST) begin
          col_cnt_next    = '0;
          block_done_next = 1'b1;
        end else begin
          col_cnt_next = col_base + 8'd1;
        end
      end else begin
        word_cnt_next = word_base + WC_W'(1);
      end
    end

    if (drop) overflow_next = 1'b1;

    // block_done_reg coincides with the last word's write strobe, so the flag follows it.
    case (state_reg)
      S_IDLE: begin
        if (block_done_reg) begin
          state_next = S_FLAG;
          timer_next = FT_LOAD;
        end
      end
      S_FLAG: begin
        if (block_done_reg) begin
          timer_next = FT_LOAD;
        end else if (timer_reg == '0) begin
          state_next = S_IDLE;
        end else begin
          timer_next = timer_reg - FT_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge fifo_wr_clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      timer_reg      <= '0;
      word_cnt_reg   <= '0;
      col_cnt_reg    <= '0;
      block_done_reg <= 1'b0;
      wr_en_reg      <= 1'b0;
      din_reg        <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      word_cnt_reg   <= word_cnt_next;
      col_cnt_reg    <= col_cnt_next;
      block_done_reg <= block_done_next;
      wr_en_reg      <= wr_en_next;
      din_reg        <= din_next;
      overflow_reg   <= overflow_next;
    end
  end

  assign fifo_wr_en   = wr_en_reg;
  assign fifo_din     = din_reg;
  assign flag_138cols = (state_reg == S_FLAG);
  assign col_count    = col_cnt_reg;
  assign overflow     = overflow_reg;

endmodule

// File: doc/fifo_col_writer.md
Name: fifo_col_writer

Overview:
- Write-side companion to the FIFO read-timing logic: packs the imager pixel word stream into the column FIFO and counts words and columns.
- Pulses flag_138cols once a full block of COLS_PER_BLOCK columns (WORDS_PER_COL words each, 552 words by default) has been committed to the FIFO.
- The reader then bursts fifo_rd_en for one block.
- Sits between the ADC/pixel capture path and the FIFO write port, in the fifo_wr_clk domain.

Parameters:
- WORD_W, 16, width of pixel word and fifo_din.
- WORDS_PER_COL, 4, FIFO words per column.
- COLS_PER_BLOCK, 138, columns per block; block size = WORDS_PER_COL*COLS_PER_BLOCK (552).
- FLAG_LEN, 1, cycles flag_138cols stays high per block (1..WORDS_PER_COL).

Ports:
- fifo_wr_clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- frame_start  in  1  one-cycle pulse; resyncs counters to block start.
- pix_valid  in  1  pix_data valid this cycle.
- pix_data  in  WORD_W  pixel word.
- fifo_full  in  1  FIFO full flag from write side.
- pix_ready  out  1  upstream may present a word (see Optional Feature).
- fifo_wr_en  out  1  FIFO write strobe, registered.
- fifo_din  out  WORD_W  FIFO write data, registered.
- flag_138cols  out  1  block-complete flag to the FIFO reader.
- col_count  out  8  columns completed in current block, 0..COLS_PER_BLOCK-1.
- overflow  out  1  sticky: a word was dropped.

Behaviour:
- Single clock, synchronous active-high rst. On rst: fifo_wr_en=0, fifo_din=0, flag_138cols=0, col_count=0, overflow=0, internal word counter=0, flag timer=0. Reset mid-block discards the partial block; no flag is issued for it.
- Accept condition: pix_valid && !fifo_full (&& pix_ready when the macro is enabled).
- On accept, the next cycle has fifo_wr_en=1 and fifo_din=pix_data (1-cycle latency). Otherwise fifo_wr_en=0 and fifo_din holds its value.
- word_cnt counts 0..WORDS_PER_COL-1. When it wraps, col_count increments.
- When col_count reaches COLS_PER_BLOCK-1 and word_cnt wraps (the 552nd accepted word), col_count wraps to 0 and the block is complete.
- flag_138cols rises the cycle after that word's fifo_wr_en cycle, so the FIFO already holds all 552 words. It stays high exactly FLAG_LEN cycles, then drops.
- Flag timer states: IDLE (flag=0) -> FLAG (flag=1, timer counts FLAG_LEN down) -> IDLE.
- Words of the next block are accepted and counted normally while FLAG is active. There is no stall between blocks.
- Dropped word: pix_valid && fifo_full sets overflow (sticky until rst). The word is not written and the counters do not advance.
- frame_start clears word_cnt and col_count. Priority: rst > frame_start > accept.
  - A word accepted in the same cycle as frame_start becomes word 0 of column 0, so the counters become word_cnt=1, col_count=0.
  - frame_start does not cancel an active flag pulse.
- Counter widths: col_count 8 bits (covers 138). word_cnt is ceil(log2(WORDS_PER_COL)) bits with a minimum of 1. No counter ever exceeds its terminal value.

Optional Feature:
- Macro FIFO_WR_BACKPRESSURE_EN.
- Defined: pix_ready = !fifo_full, registered one cycle from fifo_full and reset to 0. Accept additionally requires pix_ready. overflow is set only if pix_valid && !pix_ready && fifo_full, which upstream protocol forbids, so overflow normally stays 0.
- Undefined: pix_ready is tied to 1, and words arriving while fifo_full=1 are dropped and set overflow as described above.

Test Plan:
- rst then 552 consecutive valid words (fifo_full=0) -> 552 fifo_wr_en pulses, fifo_din equals input delayed 1 cycle; flag_138cols high exactly 1 cycle, the cycle after the 552nd write; col_count returns to 0.
- 1104 words back-to-back -> exactly two flag pulses, 552 writes apart; no gap in fifo_wr_en.
- fifo_full=1 for 10 cycles during valid words (macro off) -> 10 words missing, overflow=1 sticky, flag after 562 presented words.
- frame_start at word 300, then 552 more words -> flag after those 552 only; col_count=0 after frame_start, not 75.
- rst asserted at word 400, then 552 words -> all outputs 0 during reset; single flag after the 552 new words.
- FIFO_WR_BACKPRESSURE_EN defined, fifo_full toggled every 8 cycles while pix_valid held high -> pix_ready follows !fifo_full delayed 1 cycle, overflow stays 0, flag after 552 accepted words.
